// File: rtl/pipelined_cpu_top.sv
// Five-stage MIPS-subset CPU: IF/ID/EX/MEM/WB, branches resolved in ID
// with one delay slot, full forwarding into ID and a 1-cycle load-use stall.
module pipelined_cpu_top #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 32,
    parameter logic [IMEM_WORDS*32-1:0] IMEM_INIT = '0
) (
    input  logic        clock,
    input  logic        memclock,
    input  logic        resetn,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic [31:0] ealu,
    output logic [31:0] malu,
    output logic [31:0] walu
);
    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_WORDS);

    typedef enum logic [3:0] {
        A_ADD, A_SUB, A_AND, A_OR, A_XOR,
        A_SLL, A_SRL, A_SRA, A_LUI
    } aluc_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic        jal;
        logic        shift;
        logic        aluimm;
        aluc_t       aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc8;
        logic [4:0]  sa;
        logic [4:0]  rn;
    } id_ex_t;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
    } ex_mem_t;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [31:0] mo;
        logic [31:0] alu;
        logic [4:0]  rn;
    } mem_wb_t;

    if_id_t  d;
    id_ex_t  e, e_n;
    ex_mem_t m;
    mem_wb_t w;

    logic [31:0] rom [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] rf [32];

    // memclock exists only for pin compatibility
    logic unused_ok;
    assign unused_ok = memclock;

    // ---------------- IF ----------------
    for (genvar g = 0; g < IMEM_WORDS; g++) begin : g_rom
        assign rom[g] = IMEM_INIT[g*32 +: 32];
    end
    assign inst = rom[pc[IA+1:2]];

    // ---------------- ID ----------------
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    assign op  = d.inst[31:26];
    assign rs  = d.inst[25:21];
    assign rt  = d.inst[20:16];
    assign rd  = d.inst[15:11];
    assign sa  = d.inst[10:6];
    assign fn  = d.inst[5:0];
    assign imm = d.inst[15:0];

    logic rop;
    logic r_add, r_sub, r_and, r_or, r_xor;
    logic r_sll, r_srl, r_sra, r_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lui;
    logic i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
    assign rop    = op == 6'h00;
    assign r_add  = rop && fn == 6'h20;
    assign r_sub  = rop && fn == 6'h22;
    assign r_and  = rop && fn == 6'h24;
    assign r_or   = rop && fn == 6'h25;
    assign r_xor  = rop && fn == 6'h26;
    assign r_sll  = rop && fn == 6'h00;
    assign r_srl  = rop && fn == 6'h02;
    assign r_sra  = rop && fn == 6'h03;
    assign r_jr   = rop && fn == 6'h08;
    assign i_j    = op == 6'h02;
    assign i_jal  = op == 6'h03;
    assign i_beq  = op == 6'h04;
    assign i_bne  = op == 6'h05;
    assign i_addi = op == 6'h08;
    assign i_andi = op == 6'h0c;
    assign i_ori  = op == 6'h0d;
    assign i_xori = op == 6'h0e;
    assign i_lui  = op == 6'h0f;
    assign i_lw   = op == 6'h23;
    assign i_sw   = op == 6'h2b;

    logic  wreg, m2reg, wmem, shift, aluimm;
    logic  sext, regrt, use_rs, use_rt;
    aluc_t aluc;

    always_comb begin
        wreg = 1'b0; m2reg = 1'b0; wmem = 1'b0;
        shift = 1'b0; aluimm = 1'b0; sext = 1'b0;
        regrt = 1'b0; use_rs = 1'b0; use_rt = 1'b0;
        aluc = A_ADD;
        unique case (1'b1)
            r_add: begin wreg = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
            r_sub: begin wreg = 1'b1; use_rs = 1'b1; use_rt = 1'b1; aluc = A_SUB; end
            r_and: begin wreg = 1'b1; use_rs = 1'b1; use_rt = 1'b1; aluc = A_AND; end
            r_or:  begin wreg = 1'b1; use_rs = 1'b1; use_rt = 1'b1; aluc = A_OR; end
            r_xor: begin wreg = 1'b1; use_rs = 1'b1; use_rt = 1'b1; aluc = A_XOR; end
            r_sll: begin wreg = 1'b1; use_rt = 1'b1; shift = 1'b1; aluc = A_SLL; end
            r_srl: begin wreg = 1'b1; use_rt = 1'b1; shift = 1'b1; aluc = A_SRL; end
            r_sra: begin wreg = 1'b1; use_rt = 1'b1; shift = 1'b1; aluc = A_SRA; end
            r_jr:  use_rs = 1'b1;
            i_addi: begin wreg = 1'b1; use_rs = 1'b1; aluimm = 1'b1; sext = 1'b1; regrt = 1'b1; end
            i_andi: begin wreg = 1'b1; use_rs = 1'b1; aluimm = 1'b1; regrt = 1'b1; aluc = A_AND; end
            i_ori:  begin wreg = 1'b1; use_rs = 1'b1; aluimm = 1'b1; regrt = 1'b1; aluc = A_OR; end
            i_xori: begin wreg = 1'b1; use_rs = 1'b1; aluimm = 1'b1; regrt = 1'b1; aluc = A_XOR; end
            i_lui:  begin wreg = 1'b1; aluimm = 1'b1; regrt = 1'b1; aluc = A_LUI; end
            i_lw: begin
                wreg = 1'b1; m2reg = 1'b1; use_rs = 1'b1;
                aluimm = 1'b1; sext = 1'b1; regrt = 1'b1;
            end
            i_sw: begin
                wmem = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
                aluimm = 1'b1; sext = 1'b1;
            end
            i_beq, i_bne: begin use_rs = 1'b1; use_rt = 1'b1; end
            i_jal: wreg = 1'b1;
            default: ;
        endcase
    end

    // Forwarding into ID: EX (non-load) > MEM > WB > register file
    logic [31:0] mdata, fa, fb;
    assign mdata = m.m2reg ? dmem[m.alu[DA+1:2]] : m.alu;

    assign fa = (rs == 5'd0) ? 32'd0 :
                (e.wreg && !e.m2reg && e.rn == rs) ? ealu :
                (m.wreg && m.rn == rs) ? mdata :
                (w.wreg && w.rn == rs) ? walu : rf[rs];
    assign fb = (rt == 5'd0) ? 32'd0 :
                (e.wreg && !e.m2reg && e.rn == rt) ? ealu :
                (m.wreg && m.rn == rt) ? mdata :
                (w.wreg && w.rn == rt) ? walu : rf[rt];

    logic stall, taken;
    assign stall = e.wreg && e.m2reg && e.rn != 5'd0 &&
                   ((use_rs && e.rn == rs) || (use_rt && e.rn == rt));
    assign taken = (i_beq && fa == fb) || (i_bne && fa != fb);

    logic [31:0] npc;
    always_comb begin
        npc = pc + 32'd4;
        unique case (1'b1)
            r_jr:        npc = fa;
            i_j, i_jal:  npc = {d.pc4[31:28], d.inst[25:0], 2'b00};
            taken:       npc = d.pc4 + {{14{imm[15]}}, imm, 2'b00};
            default: ;
        endcase
    end

    always_comb begin
        e_n = '0;
        if (!stall) begin
            e_n.wreg   = wreg;
            e_n.m2reg  = m2reg;
            e_n.wmem   = wmem;
            e_n.jal    = i_jal;
            e_n.shift  = shift;
            e_n.aluimm = aluimm;
            e_n.aluc   = aluc;
            e_n.a      = fa;
            e_n.b      = fb;
            e_n.imm    = sext ? {{16{imm[15]}}, imm} : {16'h0, imm};
            e_n.pc8    = d.pc4 + 32'd4;
            e_n.sa     = sa;
            e_n.rn     = i_jal ? 5'd31 : (regrt ? rt : rd);
        end
    end

    // ---------------- EX ----------------
    logic [31:0] xa, xb, alu_r;
    assign xa = e.shift ? {27'h0, e.sa} : e.a;
    assign xb = e.aluimm ? e.imm : e.b;

    always_comb begin
        unique case (e.aluc)
            A_SUB:   alu_r = xa - xb;
            A_AND:   alu_r = xa & xb;
            A_OR:    alu_r = xa | xb;
            A_XOR:   alu_r = xa ^ xb;
            A_SLL:   alu_r = xb << xa[4:0];
            A_SRL:   alu_r = xb >> xa[4:0];
            A_SRA:   alu_r = $signed(xb) >>> xa[4:0];
            A_LUI:   alu_r = {xb[15:0], 16'h0};
            default: alu_r = xa + xb;
        endcase
    end

    assign ealu = e.jal ? e.pc8 : alu_r;

    // ---------------- MEM / WB ----------------
    assign malu = m.alu;
    assign walu = w.m2reg ? w.mo : w.alu;

    always_ff @(posedge clock) begin
        if (m.wmem) dmem[m.alu[DA+1:2]] <= m.b;
    end

    always_ff @(posedge clock) begin
        if (w.wreg && w.rn != 5'd0) rf[w.rn] <= walu;
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            pc <= '0;
            d  <= '0;
            e  <= '0;
            m  <= '0;
            w  <= '0;
        end else begin
            if (!stall) begin
                pc     <= npc;
                d.pc4  <= pc + 32'd4;
                d.inst <= inst;
            end
            e       <= e_n;
            m.wreg  <= e.wreg;
            m.m2reg <= e.m2reg;
            m.wmem  <= e.wmem;
            m.alu   <= ealu;
            m.b     <= e.b;
            m.rn    <= e.rn;
            w.wreg  <= m.wreg;
            w.m2reg <= m.m2reg;
            w.mo    <= dmem[m.alu[DA+1:2]];
            w.alu   <= m.alu;
            w.rn    <= m.rn;
        end
    end
endmodule

// File: tb/tb_pipelined_cpu_top.sv
// Directed bench: fixed program in ROM, cycle-exact checks of pc and
// per-stage debug outputs against hand-computed values.
module tb_pipelined_cpu_top;
    function automatic logic [31:0] rr(input logic [4:0] s, input logic [4:0] t,
                                       input logic [4:0] dd, input logic [4:0] sh,
                                       input logic [5:0] f);
        return {6'h00, s, t, dd, sh, f};
    endfunction

    function automatic logic [31:0] ii(input logic [5:0] o, input logic [4:0] s,
                                       input logic [4:0] t, input logic [15:0] im);
        return {o, s, t, im};
    endfunction

    function automatic logic [31:0] jj(input logic [5:0] o, input logic [25:0] a);
        return {o, a};
    endfunction

    function automatic logic [2047:0] prog();
        logic [2047:0] p;
        p = '0;
        p[0*32  +: 32] = ii(6'h08, 5'd0, 5'd1, 16'd5);
        p[1*32  +: 32] = ii(6'h08, 5'd1, 5'd2, 16'd3);
        p[2*32  +: 32] = rr(5'd2, 5'd1, 5'd3, 5'd0, 6'h22);
        p[3*32  +: 32] = ii(6'h2b, 5'd0, 5'd2, 16'd0);
        p[4*32  +: 32] = ii(6'h23, 5'd0, 5'd4, 16'd0);
        p[5*32  +: 32] = rr(5'd4, 5'd4, 5'd5, 5'd0, 6'h20);
        p[6*32  +: 32] = ii(6'h04, 5'd0, 5'd0, 16'd2);
        p[7*32  +: 32] = ii(6'h08, 5'd0, 5'd6, 16'd1);
        p[8*32  +: 32] = ii(6'h08, 5'd6, 5'd6, 16'd4);
        p[9*32  +: 32] = ii(6'h08, 5'd0, 5'd8, 16'd9);
        p[10*32 +: 32] = rr(5'd6, 5'd8, 5'd9, 5'd0, 6'h20);
        p[11*32 +: 32] = rr(5'd8, 5'd9, 5'd10, 5'd0, 6'h20);
        p[12*32 +: 32] = ii(6'h0f, 5'd0, 5'd13, 16'h8000);
        p[13*32 +: 32] = rr(5'd0, 5'd13, 5'd14, 5'd4, 6'h03);
        p[14*32 +: 32] = rr(5'd0, 5'd13, 5'd15, 5'd4, 6'h02);
        p[15*32 +: 32] = ii(6'h0d, 5'd14, 5'd16, 16'hffff);
        p[16*32 +: 32] = ii(6'h0e, 5'd16, 5'd17, 16'h00ff);
        p[17*32 +: 32] = ii(6'h0c, 5'd17, 5'd18, 16'hf0f0);
        p[18*32 +: 32] = ii(6'h05, 5'd18, 5'd0, 16'd2);
        p[19*32 +: 32] = rr(5'd0, 5'd18, 5'd19, 5'd4, 6'h00);
        p[20*32 +: 32] = ii(6'h08, 5'd19, 5'd19, 16'd1);
        p[21*32 +: 32] = rr(5'd19, 5'd19, 5'd21, 5'd0, 6'h20);
        p[22*32 +: 32] = jj(6'h03, 26'h1c);
        p[23*32 +: 32] = ii(6'h08, 5'd0, 5'd11, 16'd7);
        p[24*32 +: 32] = ii(6'h08, 5'd31, 5'd12, 16'd0);
        p[25*32 +: 32] = jj(6'h02, 26'h19);
        p[28*32 +: 32] = rr(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        return p;
    endfunction

    localparam logic [2047:0] PROG = prog();

    logic        clock = 1'b0;
    logic        memclock = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] pc, inst, ealu, malu, walu;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    pipelined_cpu_top #(
        .IMEM_WORDS(64),
        .DMEM_WORDS(32),
        .IMEM_INIT (PROG)
    ) dut (
        .clock   (clock),
        .memclock(memclock),
        .resetn  (resetn),
        .pc      (pc),
        .inst    (inst),
        .ealu    (ealu),
        .malu    (malu),
        .walu    (walu)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (5) tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_ealu", ealu, 32'h0);
        chk("rst_malu", malu, 32'h0);
        chk("rst_walu", walu, 32'h0);
        resetn = 1'b0;
        chk("inst0", inst, 32'h20010005);
        tick();                                   // n=1
        chk("pc_n1", pc, 32'h4);
        tick();                                   // n=2
        chk("pc_n2", pc, 32'h8);
        chk("addi1", ealu, 32'd5);
        tick();                                   // n=3
        chk("addi2_fwd_ex", ealu, 32'd8);
        tick();                                   // n=4
        chk("sub_fwd", ealu, 32'd3);
        tick();                                   // n=5
        chk("sw_addr", ealu, 32'd0);
        tick();                                   // n=6
        chk("sub_wb", walu, 32'd3);
        chk("pc_n6", pc, 32'h18);
        tick();                                   // n=7 stall
        chk("stall_pc_hold", pc, 32'h18);
        chk("stall_bubble", ealu, 32'd0);
        tick();                                   // n=8
        chk("loaduse_add", ealu, 32'd16);
        chk("lw_wb", walu, 32'd8);
        chk("pc_n8", pc, 32'h1c);
        tick();                                   // n=9
        chk("add_mem", malu, 32'd16);
        chk("beq_target_pc", pc, 32'h24);
        tick();                                   // n=10
        chk("delay_slot", ealu, 32'd1);
        tick();                                   // n=11
        chk("beq_target", ealu, 32'd9);
        tick();                                   // n=12
        chk("skip_check", ealu, 32'd10);
        tick();                                   // n=13
        chk("add10", ealu, 32'd19);
        tick();                                   // n=14
        chk("lui", ealu, 32'h80000000);
        tick();                                   // n=15
        chk("sra", ealu, 32'hf8000000);
        tick();                                   // n=16
        chk("srl", ealu, 32'h08000000);
        tick();                                   // n=17
        chk("ori_zext", ealu, 32'hf800ffff);
        tick();                                   // n=18
        chk("xori", ealu, 32'hf800ff00);
        tick();                                   // n=19
        chk("andi", ealu, 32'h0000f000);
        chk("pc_n19", pc, 32'h4c);
        tick();                                   // n=20
        chk("bne_target_pc", pc, 32'h54);
        tick();                                   // n=21
        chk("sll", ealu, 32'h000f0000);
        tick();                                   // n=22
        chk("bne_skip", ealu, 32'h001e0000);
        tick();                                   // n=23
        chk("jal_link", ealu, 32'h60);
        chk("jal_target_pc", pc, 32'h70);
        tick();                                   // n=24
        chk("jal_slot", ealu, 32'd7);
        tick();                                   // n=25
        chk("jr_target_pc", pc, 32'h60);
        tick();                                   // n=26
        tick();                                   // n=27
        chk("ra_readback", ealu, 32'h60);
        chk("pc_n27", pc, 32'h68);
        tick();                                   // n=28
        chk("j_loop_pc", pc, 32'h64);
        chk("pre_rst_malu", malu, 32'h60);
        #2;
        resetn = 1'b1;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_ealu", ealu, 32'h0);
        chk("async_malu", malu, 32'h0);
        chk("async_walu", walu, 32'h0);
        resetn = 1'b0;
        tick();
        chk("restart_pc1", pc, 32'h4);
        tick();
        chk("restart_pc2", pc, 32'h8);
        chk("restart_addi", ealu, 32'd5);
        tick();
        chk("restart_addi2", ealu, 32'd8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
